// File: rtl/pipe_scoreboard.sv
//==============================================================================
// Module      : pipe_scoreboard
// Description : DEPTH-stage in-flight destination tracker producing issue stall,
//               per-operand forward selects and the write-back strobe.
//               Optional perf counters: define PIPE_SCOREBOARD_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_scoreboard #(
    parameter  int NREG  = 32,
    parameter  int DEPTH = 3,
    parameter  int KILL  = 1,
    localparam int RW    = $clog2(NREG),
    localparam int SW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    input  logic          iss_wen,
    input  logic [RW-1:0] iss_rd,
    input  logic [SW-1:0] iss_lat,
    input  logic [RW-1:0] iss_rs1,
    input  logic [RW-1:0] iss_rs2,
    input  logic          iss_use1,
    input  logic          iss_use2,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd1_sel,
    output logic [SW-1:0] fwd2_sel,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic          busy,
    output logic [31:0]   stall_count,
    output logic [31:0]   flush_count
);

    logic [DEPTH-1:0] valid_q;
    logic [RW-1:0]    rd_q  [DEPTH];
    logic [SW-1:0]    rem_q [DEPTH];

    logic             hazard1;
    logic             hazard2;
    logic [SW-1:0]    lat_clamped;

    // Scan oldest to youngest so the lowest matching stage has the final say.
    always_comb begin
        fwd1_sel = '0;
        fwd2_sel = '0;
        hazard1  = 1'b0;
        hazard2  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (iss_use1 && (iss_rs1 != '0) && valid_q[k] && (rd_q[k] == iss_rs1)) begin
                fwd1_sel = (rem_q[k] == '0) ? SW'(k + 1) : '0;
                hazard1  = (rem_q[k] != '0);
            end
            if (iss_use2 && (iss_rs2 != '0) && valid_q[k] && (rd_q[k] == iss_rs2)) begin
                fwd2_sel = (rem_q[k] == '0) ? SW'(k + 1) : '0;
                hazard2  = (rem_q[k] != '0);
            end
        end
    end

    always_comb begin
        lat_clamped = iss_lat;
        if (iss_lat == '0) begin
            lat_clamped = SW'(1);
        end else if (iss_lat > SW'(DEPTH)) begin
            lat_clamped = SW'(DEPTH);
        end
    end

    assign stall    = iss_valid & ~flush & (hazard1 | hazard2);
    assign wb_valid = valid_q[DEPTH-1];
    assign wb_rd    = rd_q[DEPTH-1];
    assign busy     = |valid_q;

    // A flush squashes the issue slot and every entry sitting in the first
    // KILL stages, i.e. everything younger than the resolving branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]  <= '0;
                rem_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= iss_valid & iss_wen & (iss_rd != '0) & ~stall & ~flush;
            rd_q[0]    <= iss_rd;
            rem_q[0]   <= lat_clamped - SW'(1);
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1] & ~(flush && ((k - 1) < KILL));
                rd_q[k]    <= rd_q[k-1];
                rem_q[k]   <= (rem_q[k-1] == '0) ? '0 : rem_q[k-1] - SW'(1);
            end
        end
    end

`ifdef PIPE_SCOREBOARD_PERF_EN
    logic [31:0] stall_count_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
//==============================================================================
// Module      : tb_pipe_scoreboard
// Description : Scoreboard bench for pipe_scoreboard (DEPTH=3, KILL=1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_scoreboard;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic        iss_wen = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [1:0]  iss_lat = '0;
    logic [4:0]  iss_rs1 = '0;
    logic [4:0]  iss_rs2 = '0;
    logic        iss_use1 = 1'b0;
    logic        iss_use2 = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic [1:0]  fwd1_sel;
    logic [1:0]  fwd2_sel;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        busy;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    pipe_scoreboard #(.NREG(32), .DEPTH(DEPTH), .KILL(1)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd), .iss_lat(iss_lat),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_use1(iss_use1), .iss_use2(iss_use2),
        .flush(flush), .stall(stall), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] rd;
        int         due;
    } wb_t;
    wb_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected write-back: DEPTH cycles after the issue cycle.
    task automatic push_wb(input logic [4:0] rd);
        exp_q.push_back('{rd: rd, due: cyc + DEPTH});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                chk("wb_missing", 32'(exp_q[0].rd), 32'hFFFF);
                void'(exp_q.pop_front());
            end
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_rd), 32'hFFFF);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic drv(input logic v, input logic w, input logic [4:0] rd, input logic [1:0] lat,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic fl);
        iss_valid = v;  iss_wen = w;   iss_rd = rd;  iss_lat = lat;
        iss_rs1 = r1;   iss_use1 = u1; iss_rs2 = r2; iss_use2 = u2;
        flush = fl;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step(2);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd1", 32'(fwd1_sel), 32'd0);
        chk("rst_fwd2", 32'(fwd2_sel), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbrd", 32'(wb_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_scnt", stall_count, 32'd0);
        chk("rst_fcnt", flush_count, 32'd0);
        rst = 1'b0;
        step(1);

        // ALU back-to-back
        drv(1, 1, 5'd5, 2'd1, 5'd0, 0, 5'd0, 0, 0);
        push_wb(5'd5);
        chk("alu_issue_stall", 32'(stall), 32'd0);
        step(1);
        drv(1, 0, 5'd0, 2'd1, 5'd5, 1, 5'd0, 0, 0);
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_fwd1", 32'(fwd1_sel), 32'd1);
        chk("alu_busy", 32'(busy), 32'd1);
        step(1);
        idle();
        step(4);

        // Load-use: one stall cycle then forward from stage 1
        drv(1, 1, 5'd7, 2'd2, 5'd0, 0, 5'd0, 0, 0);
        push_wb(5'd7);
        step(1);
        drv(1, 0, 5'd0, 2'd1, 5'd0, 0, 5'd7, 1, 0);
        chk("lu_stall1", 32'(stall), 32'd1);
        step(1);
        chk("lu_stall2", 32'(stall), 32'd0);
        chk("lu_fwd2", 32'(fwd2_sel), 32'd2);
        step(1);
        idle();
        step(4);

        // Youngest matching entry wins
        drv(1, 1, 5'd3, 2'd1, 5'd0, 0, 5'd0, 0, 0);
        push_wb(5'd3);
        step(1);
        drv(1, 1, 5'd3, 2'd1, 5'd0, 0, 5'd0, 0, 0);
        push_wb(5'd3);
        step(1);
        drv(1, 0, 5'd0, 2'd1, 5'd3, 1, 5'd0, 0, 0);
        chk("young_fwd1", 32'(fwd1_sel), 32'd1);
        chk("young_stall", 32'(stall), 32'd0);
        step(1);
        idle();
        step(4);

        // Flush kills the stage-0 entry and the issuing one; stall forced low
        drv(1, 1, 5'd4, 2'd3, 5'd0, 0, 5'd0, 0, 0);
        step(1);
        drv(1, 1, 5'd9, 2'd1, 5'd4, 1, 5'd0, 0, 1);
        chk("flush_stall", 32'(stall), 32'd0);
        step(1);
        drv(1, 0, 5'd0, 2'd1, 5'd4, 1, 5'd0, 0, 0);
        chk("flush_fwd1", 32'(fwd1_sel), 32'd0);
        chk("flush_nostall", 32'(stall), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        step(1);
        idle();
        step(4);

        // x0 destination and unused operand
        drv(1, 1, 5'd5, 2'd3, 5'd0, 0, 5'd0, 0, 0);
        push_wb(5'd5);
        step(1);
        drv(1, 1, 5'd0, 2'd1, 5'd0, 0, 5'd0, 0, 0);
        step(1);
        drv(1, 0, 5'd0, 2'd1, 5'd0, 1, 5'd5, 0, 0);
        chk("x0_stall", 32'(stall), 32'd0);
        chk("x0_fwd1", 32'(fwd1_sel), 32'd0);
        chk("x0_fwd2", 32'(fwd2_sel), 32'd0);
        drv(1, 0, 5'd0, 2'd1, 5'd0, 1, 5'd5, 1, 0);
        chk("x0_use2_stall", 32'(stall), 32'd1);
        step(1);
        idle();
        step(4);

        // Latency 0 clamps to 1
        drv(1, 1, 5'd6, 2'd0, 5'd0, 0, 5'd0, 0, 0);
        push_wb(5'd6);
        step(1);
        drv(1, 0, 5'd0, 2'd1, 5'd6, 1, 5'd0, 0, 0);
        chk("lat0_fwd1", 32'(fwd1_sel), 32'd1);
        chk("lat0_stall", 32'(stall), 32'd0);
        step(1);
        idle();
        step(4);

        // Reset mid-flight discards the entry and clears counters
        drv(1, 1, 5'd8, 2'd3, 5'd0, 0, 5'd0, 0, 0);
        step(1);
        idle();
        chk("mid_busy", 32'(busy), 32'd1);
`ifdef PIPE_SCOREBOARD_PERF_EN
        chk("perf_scnt", stall_count, 32'd2);
        chk("perf_fcnt", flush_count, 32'd1);
`else
        chk("perf_scnt", stall_count, 32'd0);
        chk("perf_fcnt", flush_count, 32'd0);
`endif
        rst = 1'b1;
        step(1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_wbv", 32'(wb_valid), 32'd0);
        chk("mrst_scnt", stall_count, 32'd0);
        chk("mrst_fcnt", flush_count, 32'd0);
        rst = 1'b0;
        step(4);
        chk("after_rst_wbv", 32'(wb_valid), 32'd0);

`ifdef PIPE_SCOREBOARD_PERF_EN
        // Saturation: counter pinned at all-ones must not wrap
        drv(1, 1, 5'd10, 2'd2, 5'd0, 0, 5'd0, 0, 0);
        push_wb(5'd10);
        force dut.stall_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_count_q;
        step(1);
        drv(1, 0, 5'd0, 2'd1, 5'd10, 1, 5'd0, 0, 0);
        chk("sat_stall", 32'(stall), 32'd1);
        step(1);
        chk("sat_scnt", stall_count, 32'hFFFF_FFFF);
        idle();
        step(4);
`endif

        chk("wb_pending", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
